neighbor_sink_scanner: RTL
==========================

# neighbor_sink_scanner

Parametrised scanner that walks the node's neighbor table and known-sinks list in shared data memory and flags neighbors that are known sinks belonging to a different cluster. It replaces the fixed 64×16 first-match search with runtime-sized tables, configurable base addresses, and two modes: stop-on-first-match and count-all. It sits between the routing controller, which issues `start` and consumes `for_aggregation`, and the single-port data memory.

## Interface
- `WORD_WIDTH`, 16: width of IDs and memory data.
- `ADDR_WIDTH`, 16: memory address width.
- `NBR_BASE`, 16'h48: address of `neighborID[0]`.
- `CLU_BASE`, 16'hC8: address of `clusterID[0]`.
- `SINK_BASE`, 16'h08: address of `knownSinks[0]`.
- `STRIDE`, 2: address increment per table entry.
- `MAX_NBR`, 64: neighbor table capacity.
- `MAX_SINK`, 16: sink list capacity.
- Derived: `NW = clog2(MAX_NBR+1)`, `SW = clog2(MAX_SINK+1)`.
- `clock` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: start pulse; sampled only in IDLE.
- `mode` in 1: 0 = stop on first match; 1 = count all matching neighbors.
- `num_nbr` in NW: neighbor entries to scan; latched at start and clamped to `MAX_NBR`.
- `num_sink` in SW: sink entries to scan; latched at start and clamped to `MAX_SINK`.
- `my_cluster_id` in WORD_WIDTH: own cluster; latched at start.
- `mem_addr` out ADDR_WIDTH: registered read address.
- `mem_rd_en` out 1: registered read strobe.
- `mem_data` in WORD_WIDTH: read data, valid the cycle after `mem_addr`/`mem_rd_en` are presented.
- `busy` out 1: high from the cycle after an accepted start until done.
- `done` out 1: one-cycle completion pulse.
- `for_aggregation` out 1: at least one match found in the last scan.
- `match_count` out NW: number of matching neighbors; saturates at 1 in mode 0.
- `match_nbr_idx` out NW-1:0: neighbor index of the first match.
- `match_sink_idx` out SW-1:0: sink index of the first match.

## Operation
- States: IDLE, NBR, CLU, SINK, DONE. Neighbor index is `i`, sink index is `j`.
- IDLE:
  - On `start`, latch `mode`, the clamped counts, and `my_cluster_id`.
  - Clear `for_aggregation`, `match_count`, and both index outputs.
  - Set `i=0`.
  - If either count is 0, go to DONE and issue no reads.
  - Otherwise present `NBR_BASE`, go to NBR.
- NBR: capture `nbr=mem_data`, present `CLU_BASE+STRIDE*i`, go to CLU.
- CLU: capture `clu=mem_data`.
  - If `clu==my_cluster_id`, skip the sink scan: advance to the next neighbor.
  - Else set `j=0`, present `SINK_BASE`, go to SINK.
- SINK, when `mem_data==nbr`, record a match:
  - Set `for_aggregation=1` and increment `match_count`.
  - On the first match only, record `match_nbr_idx=i` and `match_sink_idx=j`.
  - Mode 0: go to DONE.
  - Mode 1: advance to the next neighbor. A neighbor is counted at most once.
- SINK, no match: `j++`. If `j==num_sink`, advance to the next neighbor; else present `SINK_BASE+STRIDE*j`.
- Advance to the next neighbor: `i++`. If `i==num_nbr`, go to DONE; else present `NBR_BASE+STRIDE*i`, go to NBR.
- DONE: `done=1` for one cycle, `busy=0`, return to IDLE. Results hold until the next accepted start.
- Address arithmetic is computed at ADDR_WIDTH and wraps modulo 2^ADDR_WIDTH. No bounds checking beyond the clamp.
- `mem_rd_en` is high exactly in the cycles where a new `mem_addr` is presented.

## Timing
- Reset: all outputs 0, state IDLE, `mem_addr=0`.
- Reset mid-scan aborts the scan at the next edge with no `done` pulse.
- `start` seen at edge E0: the first `mem_addr` is presented after E0, and `busy=1` from E0 onward.
- Cost per neighbor: NBR 1 cycle + CLU 1 cycle + k SINK cycles, where k = sinks compared (0 if same cluster).
- Full scan with no match and all clusters foreign: `done` is high in cycle `E0 + num_nbr*(2+num_sink) + 1`.
- Zero-count scan: `done` in the cycle after E0.
- `start` while busy or in DONE is ignored, not queued.
- `start` and `rst` in the same cycle: reset wins.

## Test plan
- Mode 0 first match: `num_nbr=4`, `num_sink=3`, `my_cluster=5`; nbr={10,11,12,13}, clu={5,7,7,7}, sinks={20,12,30} -> `for_aggregation=1`, `match_nbr_idx=2`, `match_sink_idx=1`, `match_count=1`; nbr 0 skips the sink reads.
- Mode 1 count: same memory but sinks={11,12,13} -> `match_count=3`, first-match indices (1,0), `done` once.
- No match / full length: 64×16 tables, all foreign clusters, no hits -> `for_aggregation=0`; `done` exactly 64*18+1 cycles after start; the last address read is `SINK_BASE+30`.
- Same-cluster suppression: a neighbor that is a known sink but has `clu==my_cluster` -> no match, and no SINK reads for that neighbor.
- Edge counts: `num_nbr=0` -> `done` the next cycle with zero reads; `num_sink=20` with `MAX_SINK=16` -> 16 sink reads per neighbor.
- Robustness: `rst` at cycle 7 of a scan -> outputs 0, IDLE, no `done`; `start` held high through a scan -> exactly one scan per accepted start.

Source files
------------

// File: rtl/neighbor_sink_scanner_if.sv
// neighbor_sink_scanner_if: single-port data memory read bus.
//   mem_addr  : read address, driven by the scanner (master)
//   mem_rd_en : read strobe, high only when a new address is presented
//   mem_data  : read data for the address currently on the bus (slave)
interface neighbor_sink_scanner_if #(
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd_en;
   logic [WORD_WIDTH-1:0] mem_data;
   modport master(output mem_addr, mem_rd_en, input mem_data);
   modport slave(input mem_addr, mem_rd_en, output mem_data);
endinterface

// File: rtl/neighbor_sink_scanner.sv
// neighbor_sink_scanner: walks the neighbor table and known-sinks list in data
// memory and flags neighbors that are known sinks of a foreign cluster.
//   clock, rst       : rising-edge clock, synchronous active-high reset
//   start, mode      : scan request (IDLE only); 0 = stop on first match, 1 = count all
//   num_nbr/num_sink : table lengths, latched at start and clamped to capacity
//   my_cluster_id    : own cluster, latched at start
//   mem              : memory read bus (master side)
//   busy, done       : scan in progress / one-cycle completion pulse
//   for_aggregation, match_count, match_nbr_idx, match_sink_idx : results of last scan
module neighbor_sink_scanner #(
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] NBR_BASE  = 16'h48,
   parameter logic [ADDR_WIDTH-1:0] CLU_BASE  = 16'hC8,
   parameter logic [ADDR_WIDTH-1:0] SINK_BASE = 16'h08,
   parameter int STRIDE   = 2,
   parameter int MAX_NBR  = 64,
   parameter int MAX_SINK = 16,
   localparam int NW = $clog2(MAX_NBR + 1),
   localparam int SW = $clog2(MAX_SINK + 1)
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [NW-1:0]         num_nbr,
   input  logic [SW-1:0]         num_sink,
   input  logic [WORD_WIDTH-1:0] my_cluster_id,
   neighbor_sink_scanner_if.master mem,
   output logic                  busy,
   output logic                  done,
   output logic                  for_aggregation,
   output logic [NW-1:0]         match_count,
   output logic [NW-1:0]         match_nbr_idx,
   output logic [SW-1:0]         match_sink_idx
);
   typedef enum logic [2:0] {IDLE, NBR, CLU, SINK, DONE} state_t;
   state_t                state;
   logic                  md;
   logic [NW-1:0]         n_nbr, i, i_nx, nbr_c;
   logic [SW-1:0]         n_sink, j, j_nx, sink_c;
   logic [WORD_WIDTH-1:0] my_clu, nbr;
   function automatic logic [ADDR_WIDTH-1:0] at(input logic [ADDR_WIDTH-1:0] base, idx);
      return base + ADDR_WIDTH'(STRIDE) * idx;
   endfunction
   always_comb begin
      i_nx   = i + 1'b1;
      j_nx   = j + 1'b1;
      nbr_c  = (num_nbr > NW'(MAX_NBR)) ? NW'(MAX_NBR) : num_nbr;
      sink_c = (num_sink > SW'(MAX_SINK)) ? SW'(MAX_SINK) : num_sink;
   end
   always_ff @(posedge clock) begin
      if (rst) begin
         state           <= IDLE;
         md              <= 1'b0;
         n_nbr           <= '0;
         n_sink          <= '0;
         i               <= '0;
         j               <= '0;
         my_clu          <= '0;
         nbr             <= '0;
         mem.mem_addr    <= '0;
         mem.mem_rd_en   <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         for_aggregation <= 1'b0;
         match_count     <= '0;
         match_nbr_idx   <= '0;
         match_sink_idx  <= '0;
      end else begin
         mem.mem_rd_en <= 1'b0;
         done          <= 1'b0;
         case (state)
            IDLE: if (start) begin
               md              <= mode;
               n_nbr           <= nbr_c;
               n_sink          <= sink_c;
               my_clu          <= my_cluster_id;
               for_aggregation <= 1'b0;
               match_count     <= '0;
               match_nbr_idx   <= '0;
               match_sink_idx  <= '0;
               i               <= '0;
               if (nbr_c == '0 || sink_c == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state         <= NBR;
                  busy          <= 1'b1;
                  mem.mem_addr  <= NBR_BASE;
                  mem.mem_rd_en <= 1'b1;
               end
            end
            NBR: begin
               nbr           <= mem.mem_data;
               mem.mem_addr  <= at(CLU_BASE, ADDR_WIDTH'(i));
               mem.mem_rd_en <= 1'b1;
               state         <= CLU;
            end
            CLU: if (mem.mem_data == my_clu) begin
               // own-cluster neighbor: never a candidate, skip its sink reads
               i <= i_nx;
               if (i_nx == n_nbr) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state         <= NBR;
                  mem.mem_addr  <= at(NBR_BASE, ADDR_WIDTH'(i_nx));
                  mem.mem_rd_en <= 1'b1;
               end
            end else begin
               j             <= '0;
               mem.mem_addr  <= SINK_BASE;
               mem.mem_rd_en <= 1'b1;
               state         <= SINK;
            end
            SINK: if (mem.mem_data == nbr || j_nx == n_sink) begin
               if (mem.mem_data == nbr) begin
                  for_aggregation <= 1'b1;
                  match_count     <= match_count + 1'b1;
                  // for_aggregation still low means this is the first match of the scan
                  if (!for_aggregation) begin
                     match_nbr_idx  <= i;
                     match_sink_idx <= j;
                  end
               end
               i <= i_nx;
               if ((mem.mem_data == nbr && !md) || i_nx == n_nbr) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state         <= NBR;
                  mem.mem_addr  <= at(NBR_BASE, ADDR_WIDTH'(i_nx));
                  mem.mem_rd_en <= 1'b1;
               end
            end else begin
               j             <= j_nx;
               mem.mem_addr  <= at(SINK_BASE, ADDR_WIDTH'(j_nx));
               mem.mem_rd_en <= 1'b1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
